prefetch_fifo_ctl: RTL

//  Parametrised instruction prefetch queue with its own bus-fetch controller.

---
 rtl/prefetch_fifo_ctl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/prefetch_fifo_ctl.sv
// Instruction prefetch queue with its own bus-fetch controller. The queue is kept as a
// shift array (index 0 = oldest) whose slots at or beyond level always hold zero.
module prefetch_fifo_ctl #(
  parameter int DEPTH      = 16,
  parameter int BUS_BYTES  = 2,
  parameter int PEEK_BYTES = 4,
  parameter int ADDR_W     = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush,
  input  logic [ADDR_W-1:0]                 flush_addr,
  output logic                              fetch_req,
  output logic [ADDR_W-1:0]                 fetch_addr,
  input  logic                              fetch_ack,
  input  logic [8*BUS_BYTES-1:0]            fetch_data,
  input  logic [$clog2(PEEK_BYTES+1)-1:0]   pop_count,
  output logic [8*PEEK_BYTES-1:0]           data_out,
  output logic [$clog2(DEPTH+1)-1:0]        level,
  output logic                              empty,
  output logic                              full,
  output logic [ADDR_W-1:0]                 pfp
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam bit BUS2 = (BUS_BYTES == 2);
  localparam logic [LW-1:0] FREE_LIM = LW'(DEPTH - BUS_BYTES);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DISCARD = 2'd2} state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] pfp_r;
  logic [ADDR_W-1:0] fetch_addr_r;
  logic [LW-1:0]     level_r;
  logic              empty_r;
  logic              full_r;
  logic [7:0]        q_r      [DEPTH];
  logic [7:0]        q_next_s [DEPTH];
  logic [7:0]        lane_byte_s [BUS_BYTES];

  logic [LW-1:0]     off_s;
  logic [LW-1:0]     n_s;
  logic [LW-1:0]     pop_ext_s;
  logic [LW-1:0]     pop_s;
  logic              push_s;
  logic [LW-1:0]     level_next_s;
  logic [ADDR_W-1:0] pfp_inc_s;

  function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a);
    return BUS2 ? {a[ADDR_W-1:1], 1'b0} : a;
  endfunction

  // Fetch acceptance: only the lanes at and above pfp's offset belong to the stream.
  assign off_s        = BUS2 ? LW'(pfp_r[0]) : {LW{1'b0}};
  assign n_s          = LW'(BUS_BYTES) - off_s;
  assign pfp_inc_s    = pfp_r + ADDR_W'(n_s);
  assign pop_ext_s    = LW'(pop_count);
  assign pop_s        = (pop_ext_s > level_r) ? level_r : pop_ext_s;
  assign push_s       = (state_r == REQ) && fetch_ack && !flush;
  assign level_next_s = flush ? {LW{1'b0}}
                              : (level_r - pop_s + (push_s ? n_s : {LW{1'b0}}));

  // Next queue image: shift out popped bytes, then append accepted bytes at level-p.
  always_comb begin
    for (int b = 0; b < BUS_BYTES; b++) begin
      lane_byte_s[b] = 8'h00;
      for (int l = 0; l < BUS_BYTES; l++) begin
        lane_byte_s[b] = (l == int'(off_s) + b) ? fetch_data[8*l +: 8] : lane_byte_s[b];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      q_next_s[i] = 8'h00;
      for (int j = 0; j <= PEEK_BYTES; j++) begin
        q_next_s[i] = (!flush && int'(pop_s) == j && (i + j) < DEPTH)
                      ? q_r[(i + j) % DEPTH] : q_next_s[i];
      end
      for (int b = 0; b < BUS_BYTES; b++) begin
        q_next_s[i] = (push_s && b < int'(n_s) && i == int'(level_r - pop_s) + b)
                      ? lane_byte_s[b] : q_next_s[i];
      end
    end
  end

  // Controller FSM plus queue, pointer and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      pfp_r        <= {ADDR_W{1'b0}};
      fetch_addr_r <= {ADDR_W{1'b0}};
      level_r      <= {LW{1'b0}};
      empty_r      <= 1'b1;
      full_r       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) q_r[i] <= 8'h00;
    end else begin
      level_r <= level_next_s;
      q_r     <= q_next_s;
      empty_r <= (level_next_s == {LW{1'b0}});
      full_r  <= (level_next_s > FREE_LIM);
      case (state_r)
        IDLE: begin
          if (flush) begin
            pfp_r <= flush_addr;
          end else if (level_r <= FREE_LIM) begin
            state_r      <= REQ;
            fetch_addr_r <= align_addr(pfp_r);
          end
        end
        REQ: begin
          if (flush) begin
            pfp_r   <= flush_addr;
            state_r <= fetch_ack ? IDLE : DISCARD;
          end else if (fetch_ack) begin
            pfp_r <= pfp_inc_s;
            if (level_next_s <= FREE_LIM) fetch_addr_r <= align_addr(pfp_inc_s);
            else state_r <= IDLE;
          end
        end
        DISCARD: begin
          // The old bus cycle is still owed an ack; its data is never queued.
          if (flush) pfp_r <= flush_addr;
          if (fetch_ack) state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < PEEK_BYTES; k++) begin : g_peek
    assign data_out[8*k +: 8] = q_r[k];
  end

  assign fetch_req  = (state_r != IDLE);
  assign fetch_addr = fetch_addr_r;
  assign level      = level_r;
  assign empty      = empty_r;
  assign full       = full_r;
  assign pfp        = pfp_r;

endmodule
